line_buffer_reader: RTL and testbench

Consumer side of the rasterizer's 64x64 one-bit `line_buffer`. On `start` it snapshots the 4096-bit buffer. It scans the snapshot in raster order and emits the (x, y) coordinate of every set pixel over a valid/ready stream to the downstream pixel writer. It pulses `done` when the scan completes, so a new line can be rasterized while the previous snapshot drains.

---
 rtl/gpu_raster_pkg.sv | 20 ++
 rtl/line_row_select.sv | 14 +
 rtl/line_buffer_reader.sv | 142 ++++++++++++++
 tb/tb_line_buffer_reader.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/gpu_raster_pkg.sv
// Shared rasterizer constants and the line_buffer_reader state encoding.
package gpu_raster_pkg;

    localparam int GRID_DIM  = 64;
    localparam int GRID_BITS = GRID_DIM * GRID_DIM;
    localparam int COORD_W   = 6;
    localparam int IDX_W     = 2 * COORD_W;
    localparam int COUNT_W   = IDX_W + 1;

    localparam logic [IDX_W-1:0] IDX_ONE  = 12'd1;
    localparam logic [IDX_W-1:0] ROW_STEP = 12'd64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } lbr_state_t;

endpackage

// File: rtl/line_row_select.sv
// Combinational row picker: one 64-bit row of the snapshot plus an all-zero flag.
module line_row_select
    import gpu_raster_pkg::*;
(
    input  logic [GRID_BITS-1:0] snap,
    input  logic [COORD_W-1:0]   row_idx,
    output logic [GRID_DIM-1:0]  row,
    output logic                 row_empty
);

    assign row       = snap[row_idx * GRID_DIM +: GRID_DIM];
    assign row_empty = (row == {GRID_DIM{1'b0}});

endmodule

// File: rtl/line_buffer_reader.sv
// Snapshots the 64x64 line buffer and streams set-pixel coordinates in raster order.
// Optional build macro LBR_ROW_SKIP_EN skips an all-zero row in a single scan cycle.
module line_buffer_reader
    import gpu_raster_pkg::*;
(
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic [GRID_BITS-1:0] line_buffer,
    input  logic                 pix_ready,
    output logic                 pix_valid,
    output logic [COORD_W-1:0]   pix_x,
    output logic [COORD_W-1:0]   pix_y,
    output logic                 busy,
    output logic                 done,
    output logic [COUNT_W-1:0]   pix_count
);

    lbr_state_t           state_r, state_s;
    logic [GRID_BITS-1:0] snap_r;
    logic [IDX_W-1:0]     idx_r, idx_s;
    logic [COUNT_W-1:0]   count_r, count_s;
    logic                 valid_r, valid_s;
    logic [COORD_W-1:0]   x_r, x_s, y_r, y_s;
    logic                 busy_r, done_r;
    logic                 snap_load_s;
    logic [GRID_DIM-1:0]  row_s;
    logic                 row_empty_s, bit_s, last_s, last_row_s;

    line_row_select u_row_select (
        .snap      (snap_r),
        .row_idx   (idx_r[IDX_W-1:COORD_W]),
        .row       (row_s),
        .row_empty (row_empty_s)
    );

    // An empty row can never yield a set bit, so the flag gates the bit test.
    assign bit_s      = row_empty_s ? 1'b0 : row_s[idx_r[COORD_W-1:0]];
    assign last_s     = (idx_r == {IDX_W{1'b1}});
    assign last_row_s = (idx_r[IDX_W-1:COORD_W] == {COORD_W{1'b1}});

    // Next-state and datapath update for the scan FSM.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        count_s     = count_r;
        valid_s     = valid_r;
        x_s         = x_r;
        y_s         = y_r;
        snap_load_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    snap_load_s = 1'b1;
                    idx_s       = {IDX_W{1'b0}};
                    count_s     = {COUNT_W{1'b0}};
                    state_s     = SCAN;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
`ifdef LBR_ROW_SKIP_EN
                if ((idx_r[COORD_W-1:0] == {COORD_W{1'b0}}) && row_empty_s) begin
                    if (last_row_s) begin
                        state_s = DONE;
                    end else begin
                        idx_s = idx_r + ROW_STEP;
                    end
                end else
`endif
                if (bit_s) begin
                    x_s     = idx_r[COORD_W-1:0];
                    y_s     = idx_r[IDX_W-1:COORD_W];
                    valid_s = 1'b1;
                    state_s = EMIT;
                end else if (last_s) begin
                    state_s = DONE;
                end else begin
                    idx_s = idx_r + IDX_ONE;
                end
            end
            EMIT: begin
                if (pix_ready) begin
                    count_s = count_r + 13'd1;
                    valid_s = 1'b0;
                    if (last_s) begin
                        state_s = DONE;
                    end else begin
                        idx_s   = idx_r + IDX_ONE;
                        state_s = SCAN;
                    end
                end else begin
                    state_s = EMIT;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, snapshot and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_r <= IDLE;
            snap_r  <= {GRID_BITS{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            count_r <= {COUNT_W{1'b0}};
            valid_r <= 1'b0;
            x_r     <= {COORD_W{1'b0}};
            y_r     <= {COORD_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            if (snap_load_s) begin
                snap_r <= line_buffer;
            end else begin
                snap_r <= snap_r;
            end
            idx_r   <= idx_s;
            count_r <= count_s;
            valid_r <= valid_s;
            x_r     <= x_s;
            y_r     <= y_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
        end
    end

    assign pix_valid = valid_r;
    assign pix_x     = x_r;
    assign pix_y     = y_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pix_count = count_r;

endmodule

// File: tb/tb_line_buffer_reader.sv
// Table-driven bench for line_buffer_reader; cycle 0 is the cycle in which start is sampled.
module tb_line_buffer_reader;

    localparam int NB = 4096;
`ifdef LBR_ROW_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          start = 1'b0;
    logic          pix_ready = 1'b0;
    logic [NB-1:0] line_buffer = '0;
    logic          pix_valid;
    logic [5:0]    pix_x, pix_y;
    logic          busy, done;
    logic [12:0]   pix_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    line_buffer_reader dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .line_buffer (line_buffer),
        .pix_ready   (pix_ready),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .busy        (busy),
        .done        (done),
        .pix_count   (pix_count)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [NB-1:0] lb;
        int            stall;
        int            exp_count;
        int            exp_done;
        int            first_cyc;
        bit            disturb;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v, input int vi);
        int exp_q[$];
        int k = 0, c = 1, wait_cnt = 0, done_cyc = -1, first_seen = -1, hx = 0, hy = 0;
        for (int i = 0; i < NB; i++) if (v.lb[i]) exp_q.push_back(i);
        @(negedge clk);
        line_buffer = v.lb;
        start       = 1'b1;
        pix_ready   = (v.stall == 0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        while (done_cyc < 0 && c < 20000) begin
            if (v.disturb && c >= 50 && c < 53) begin
                start       = 1'b1;
                line_buffer = '1;
            end else begin
                start = 1'b0;
            end
            if (c == 1) check($sformatf("v%0d busy_c1", vi), int'(busy), 1);
            if (done) done_cyc = c;
            if (pix_valid) begin
                if (wait_cnt == 0) begin
                    if (first_seen < 0) first_seen = c;
                    check($sformatf("v%0d coord%0d", vi, k), int'({pix_y, pix_x}),
                          (k < exp_q.size()) ? exp_q[k] : -1);
                    hx = int'(pix_x);
                    hy = int'(pix_y);
                end else begin
                    check($sformatf("v%0d stable_x", vi), int'(pix_x), hx);
                    check($sformatf("v%0d stable_y", vi), int'(pix_y), hy);
                end
                if (wait_cnt >= v.stall) begin
                    pix_ready = 1'b1;
                    wait_cnt  = 0;
                    k++;
                end else begin
                    pix_ready = 1'b0;
                    wait_cnt++;
                end
            end else begin
                pix_ready = (v.stall == 0);
            end
            @(posedge clk);
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        check($sformatf("v%0d done_cycle", vi), done_cyc, v.exp_done);
        check($sformatf("v%0d emits", vi), k, v.exp_count);
        if (v.first_cyc != 0) check($sformatf("v%0d first_valid_cycle", vi), first_seen, v.first_cyc);
        check($sformatf("v%0d done_one_cycle", vi), int'(done), 0);
        check($sformatf("v%0d busy_after", vi), int'(busy), 0);
        check($sformatf("v%0d pix_count", vi), int'(pix_count), v.exp_count);
        pix_ready = 1'b0;
    endtask

    initial begin
        logic [NB-1:0] lb;
        int c;
        int n_done;

        // Vector table: buffer, stall, count, done cycle (default / row skip), first valid cycle.
        lb = '0;
        vecs[0] = '{lb, 0, 0, SKIP ? 65 : 4097, 0, 1'b0};
        lb = '0; lb[3] = 1'b1;
        vecs[1] = '{lb, 0, 1, SKIP ? 129 : 4098, 5, 1'b0};
        lb = '0; lb[0] = 1'b1; lb[4095] = 1'b1;
        vecs[2] = '{lb, 10, 2, SKIP ? 213 : 4119, 2, 1'b0};
        lb = '0; for (int i = 0; i < 64; i++) lb[i * 65] = 1'b1;
        vecs[3] = '{lb, 0, 64, 4161, 2, 1'b0};
        lb = '0; for (int i = 4032; i < 4096; i++) lb[i] = 1'b1;
        vecs[4] = '{lb, 2, 64, SKIP ? 320 : 4289, SKIP ? 65 : 4034, 1'b0};
        lb = '0; lb[10 * 64 + 5] = 1'b1;
        vecs[5] = '{lb, 0, 1, SKIP ? 129 : 4098, SKIP ? 17 : 647, 1'b0};
        lb = '0; lb[3] = 1'b1; lb[4000] = 1'b1;
        vecs[6] = '{lb, 0, 2, SKIP ? 193 : 4099, 5, 1'b1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst pix_valid", int'(pix_valid), 0);
        check("rst pix_x", int'(pix_x), 0);
        check("rst pix_y", int'(pix_y), 0);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst pix_count", int'(pix_count), 0);
        n_rst = 1'b1;

        for (int vi = 0; vi < 7; vi++) run_vec(vecs[vi], vi);

        // Reset while stalled in EMIT after one pixel was accepted.
        lb = '0; lb[100] = 1'b1; lb[200] = 1'b1;
        @(negedge clk);
        line_buffer = lb;
        start       = 1'b1;
        pix_ready   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (!pix_valid && c < 500) begin @(posedge clk); @(negedge clk); c++; end
        check("mid wait_first", int'(pix_valid), 1);
        @(posedge clk);
        @(negedge clk);
        pix_ready = 1'b0;
        c = 0;
        while (!pix_valid && c < 500) begin @(posedge clk); @(negedge clk); c++; end
        check("mid wait_second", int'(pix_valid), 1);
        check("mid second_coord", int'({pix_y, pix_x}), 200);
        repeat (3) begin @(posedge clk); @(negedge clk); end
        check("mid count_before", int'(pix_count), 1);
        n_rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid rst pix_valid", int'(pix_valid), 0);
        check("mid rst busy", int'(busy), 0);
        check("mid rst pix_count", int'(pix_count), 0);
        check("mid rst pix_x", int'(pix_x), 0);
        check("mid rst pix_y", int'(pix_y), 0);
        check("mid rst done", int'(done), 0);
        n_rst     = 1'b1;
        pix_ready = 1'b1;
        n_done    = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy || pix_valid) n_done++;
        end
        check("mid no_activity_after_abort", n_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
